// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
//   Input stage of the systolic array. Accepts K row-vectors of LANES
//   elements over a valid/ready stream and presents them to the array edge
//   diagonally skewed: lane i is delayed by i steps, with zeros as padding.
//   After the last beat, LANES-1 zero steps drain the diagonal. A one-cycle
//   done pulse then ends the job.
//
// Ports
//   clk        clock; all logic updates on the rising edge
//   rst        synchronous, active-high reset; aborts any job in progress
//   start      begins a job; sampled only in IDLE
//   len        beat count K for the job; sampled with start
//   hold       array stall; freezes all stepping
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready
//   in_data    lane i = bits [i*WIDTH +: WIDTH]
//   out_en     array advance strobe; high for one cycle after each step
//   out_data   skewed lane data, same packing as in_data
//   out_lvalid bit i set when lane i carries a real element
//   busy       high in STREAM and DRAIN
//   done       one-cycle pulse at job end
module systolic_skew_feeder #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int LEN_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     hold,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   in_data,
  output logic                     out_en,
  output logic [LANES*WIDTH-1:0]   out_data,
  output logic [LANES-1:0]         out_lvalid,
  output logic                     busy,
  output logic                     done
);

  localparam int DW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   beats_q, beats_d;   // beats still to accept
  logic [DW-1:0]      drain_q, drain_d;   // drain steps already taken

  logic                           accept;
  logic                           step;
  logic [LANES-1:0][WIDTH-1:0]    feed_data;
  logic [LANES-1:0]               feed_vld;
  logic [LANES-1:0][WIDTH-1:0]    tail_data;
  logic [LANES-1:0]               tail_vld;
  logic [LANES-1:0][WIDTH-1:0]    out_data_q;
  logic [LANES-1:0]               out_lvalid_q;
  logic                           out_en_q;

  assign in_ready = (state_q == S_STREAM) && !hold;
  assign accept   = in_ready && in_valid;
  assign step     = accept || ((state_q == S_DRAIN) && !hold);

  // Zeros (marked invalid) enter the delay lines while draining.
  assign feed_data = (state_q == S_STREAM) ? in_data : '0;
  assign feed_vld  = {LANES{state_q == S_STREAM}};

  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    drain_d = drain_q;
    unique case (state_q)
      S_IDLE: begin
        drain_d = '0;
        if (start) begin
          if (len == '0) begin
            state_d = S_DONE;
          end else begin
            beats_d = len;
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (accept) begin
          beats_d = beats_q - LEN_W'(1);
          if (beats_q == LEN_W'(1)) begin
            state_d = (LANES > 1) ? S_DRAIN : S_DONE;
          end
        end
      end
      S_DRAIN: begin
        if (!hold) begin
          if (drain_q == DW'(LANES - 2)) begin
            state_d = S_DONE;
          end else begin
            drain_d = drain_q + DW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beats_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      drain_q <= drain_d;
    end
  end

  // Per-lane delay lines: lane i holds i stages, lane 0 feeds straight through.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (i == 0) begin : g_direct
      assign tail_data[0] = feed_data[0];
      assign tail_vld[0]  = feed_vld[0];
    end else begin : g_delay
      logic [i-1:0][WIDTH-1:0] line_q;
      logic [i-1:0]            lvld_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          line_q <= '0;
          lvld_q <= '0;
        end else if (step) begin
          line_q[0] <= feed_data[i];
          lvld_q[0] <= feed_vld[i];
          for (int unsigned j = 1; j < i; j++) begin
            line_q[j] <= line_q[j-1];
            lvld_q[j] <= lvld_q[j-1];
          end
        end
      end

      assign tail_data[i] = line_q[i-1];
      assign tail_vld[i]  = lvld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_en_q     <= 1'b0;
      out_data_q   <= '0;
      out_lvalid_q <= '0;
    end else begin
      out_en_q <= step;
      if (step) begin
        out_data_q   <= tail_data;
        out_lvalid_q <= tail_vld;
      end
    end
  end

  assign out_en     = out_en_q;
  assign out_data   = out_data_q;
  assign out_lvalid = out_lvalid_q;
  assign busy       = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder
//   Directed bench for systolic_skew_feeder (WIDTH=8, LANES=4, LEN_W=16).
//   Drivers push hand-computed step outputs into a queue; a negedge monitor
//   pops one entry per out_en pulse and also checks that outputs hold when
//   no step occurred.
module tb_systolic_skew_feeder;
  localparam int W  = 8;
  localparam int L  = 4;
  localparam int LW = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LW-1:0]    len = '0;
  logic             hold = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [L*W-1:0]   in_data = '0;
  logic             out_en;
  logic [L*W-1:0]   out_data;
  logic [L-1:0]     out_lvalid;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  systolic_skew_feeder #(.WIDTH(W), .LANES(L), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .hold       (hold),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_en     (out_en),
    .out_data   (out_data),
    .out_lvalid (out_lvalid),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [L*W-1:0] d;
    logic [L-1:0]   v;
    logic           last;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   pulses = 0;
  int   bare_done = 0;
  time  t_start = 0;
  logic rst_edge = 1'b1;
  logic [L*W-1:0] prev_d = '0;
  logic [L-1:0]   prev_v = '0;

  // K=3, beat b lane i = 16*b+i; packed {lane3,lane2,lane1,lane0}.
  logic [L*W-1:0] t1_d [6] = '{32'h0000_0000, 32'h0000_0110, 32'h0002_1120,
                               32'h0312_2100, 32'h1322_0000, 32'h2300_0000};
  logic [L-1:0]   t1_v [6] = '{4'b0001, 4'b0011, 4'b0111,
                               4'b1110, 4'b1100, 4'b1000};
  // K=1, lane i = 0x40+i.
  logic [L*W-1:0] t5_d [4] = '{32'h0000_0040, 32'h0000_4100,
                               32'h0042_0000, 32'h4300_0000};
  logic [L-1:0]   t5_v [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_t1(input int n, input bit last_on_end);
    for (int s = 0; s < n; s++) begin
      exp_t e;
      e.d = t1_d[s];
      e.v = t1_v[s];
      e.last = last_on_end && (s == n - 1);
      q.push_back(e);
    end
  endtask

  task automatic push_t5();
    for (int s = 0; s < 4; s++) begin
      exp_t e;
      e.d = t5_d[s];
      e.v = t5_v[s];
      e.last = (s == 3);
      q.push_back(e);
    end
  endtask

  always @(posedge clk) rst_edge <= rst;

  // Monitor: one queue entry per out_en; otherwise outputs must hold
  // (or read zero right after a reset edge).
  always @(negedge clk) begin
    if (out_en) begin
      pulses++;
      if (q.size() == 0) begin
        chk("unexpected_out_en", 64'(out_data), 64'(0));
        tests--;  // keep the count honest if data happens to be zero
        fails++;
        tests++;
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("step_data", 64'(out_data), 64'(e.d));
        chk("step_lvalid", 64'(out_lvalid), 64'(e.v));
        chk("step_done", 64'(done), 64'(e.last));
      end
    end else begin
      chk("hold_data", 64'(out_data), rst_edge ? 64'(0) : 64'(prev_d));
      chk("hold_lvalid", 64'(out_lvalid), rst_edge ? 64'(0) : 64'(prev_v));
      if (done) begin
        chk("bare_done_expected", 64'(bare_done > 0), 64'(1));
        if (bare_done > 0) bare_done--;
      end
    end
    prev_d = out_data;
    prev_v = out_lvalid;
  end

  task automatic start_job(input int k);
    @(posedge clk);
    #1;
    start = 1'b1;
    len   = LW'(k);
    @(posedge clk);
    t_start = $time;
    pulses  = 0;
    #1;
    start = 1'b0;
    len   = '0;
  endtask

  task automatic feed_beat(input int b, input int base);
    int guard;
    bit acc;
    guard = 0;
    acc   = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < L; i++) in_data[i*W +: W] = W'(base + 16*b + i);
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = in_ready;
      chk("busy_streaming", 64'(busy), 64'(1));
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    chk("beat_accept", 64'(acc), 64'(1));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input int exp_pulses);
    int guard;
    bit seen;
    int lat;
    guard = 0;
    seen  = 1'b0;
    while (!seen && guard < 200) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      guard++;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'(1));
    lat = int'(($time - t_start - 5) / 10);
    chk({tag, "_done_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    #1;
    chk({tag, "_pulse_count"}, 64'(pulses), 64'(exp_pulses));
    chk({tag, "_queue_empty"}, 64'(q.size()), 64'(0));
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_en", 64'(out_en), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_lvalid", 64'(out_lvalid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // T1: K=3, continuous beats
    push_t1(6, 1'b1);
    start_job(3);
    for (int b = 0; b < 3; b++) feed_beat(b, 0);
    wait_done("t1", 6, 6);

    // T2: len=0 -> done next cycle, no out_en, never busy
    bare_done = 1;
    start_job(0);
    wait_done("t2", 0, 0);
    chk("t2_bare_done_used", 64'(bare_done), 64'(0));

    // T3: K=3 with in_valid low for 3 cycles after beat 0
    push_t1(6, 1'b1);
    start_job(3);
    feed_beat(0, 0);
    idle_cycles(3);
    feed_beat(1, 0);
    feed_beat(2, 0);
    wait_done("t3", 9, 6);

    // T4: hold for 3 cycles at the start of DRAIN
    push_t1(6, 1'b1);
    start_job(3);
    for (int b = 0; b < 3; b++) feed_beat(b, 0);
    hold = 1'b1;
    idle_cycles(3);
    hold = 1'b0;
    wait_done("t4", 9, 6);

    // T5: reset after 2 accepted beats, then a K=1 job
    push_t1(2, 1'b0);
    start_job(4);
    feed_beat(0, 0);
    feed_beat(1, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_in_ready", 64'(in_ready), 64'(0));
    chk("t5_out_en", 64'(out_en), 64'(0));
    chk("t5_out_data", 64'(out_data), 64'(0));
    chk("t5_out_lvalid", 64'(out_lvalid), 64'(0));
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_done", 64'(done), 64'(0));
    chk("t5_queue_empty", 64'(q.size()), 64'(0));
    idle_cycles(4);
    push_t5();
    start_job(1);
    feed_beat(0, 'h40);
    wait_done("t5b", 4, 4);

    // T6: start (len=0) pulsed during STREAM is ignored
    push_t1(6, 1'b1);
    start_job(3);
    feed_beat(0, 0);
    start = 1'b1;
    len   = '0;
    feed_beat(1, 0);
    start = 1'b0;
    feed_beat(2, 0);
    wait_done("t6", 6, 6);

    idle_cycles(4);
    chk("final_queue_empty", 64'(q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
